// File: rtl/desc_feeder.sv
// desc_feeder
// ---------------------------------------------------------------------------
// Transmit side of the descriptor-load interface into the 16x16 NCC PE grid.
// Takes a descriptor as a stream of PIX_W-bit pixels and packs four pixels
// per word, with the first pixel in the top byte. Packed words go through a
// small FIFO. They are then handed to the NCC one at a time with a
// ready/acknowledge handshake. Completion is flagged when every word has
// been acknowledged.
//
// Ports:
//   clk                  rising-edge clock
//   rst                  asynchronous, active-low reset
//   start                begin a new descriptor load (honoured in IDLE only)
//   pix_valid/pix_data   upstream pixel stream
//   pix_ready            pixel accepted when pix_valid && pix_ready
//   desc_data            packed word presented to the NCC
//   desc_data_ready      desc_data valid, held until acknowledged
//   done_with_desc_data  NCC acknowledge of the presented word
//   busy                 load in progress (LOAD or DONE)
//   desc_loaded          one-cycle pulse after the final acknowledge
//   word_count           words acknowledged so far (wraps on the final one)
//   start_err            sticky flag: start seen while busy
//
// Optional build macro DESC_FEEDER_CHECKSUM_EN adds desc_checksum, the
// 16-bit modular sum of every pixel accepted since the last start.
// ---------------------------------------------------------------------------
module desc_feeder #(
  parameter int NUM_WORDS  = 64,
  parameter int FIFO_DEPTH = 4,
  parameter int PIX_W      = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         pix_valid,
  input  logic [PIX_W-1:0]             pix_data,
  output logic                         pix_ready,
  output logic [4*PIX_W-1:0]           desc_data,
  output logic                         desc_data_ready,
  input  logic                         done_with_desc_data,
  output logic                         busy,
  output logic                         desc_loaded,
  output logic [$clog2(NUM_WORDS)-1:0] word_count,
  output logic                         start_err
`ifdef DESC_FEEDER_CHECKSUM_EN
  ,
  output logic [15:0]                  desc_checksum
`endif
);

  localparam int WORD_W = 4 * PIX_W;
  localparam int WC_W   = $clog2(NUM_WORDS);
  localparam int PC_W   = $clog2(4 * NUM_WORDS) + 1;
  localparam int AW     = $clog2(FIFO_DEPTH);

  localparam logic [PC_W-1:0] PIX_TOTAL = PC_W'(4 * NUM_WORDS);
  localparam logic [WC_W-1:0] WORD_LAST = WC_W'(NUM_WORDS - 1);
  localparam logic [AW:0]     FIFO_FULL = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t              state_q, state_d;
  logic [PC_W-1:0]     pix_cnt_q;
  logic [1:0]          byte_cnt_q;
  logic [3*PIX_W-1:0]  pack_q;
  logic [WORD_W-1:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [AW:0]         fifo_cnt_q;
  logic [WORD_W-1:0]   data_q;
  logic                ready_q;
  logic                ack_prev_q;
  logic [WC_W-1:0]     word_cnt_q;
  logic                err_q;

  logic pix_acc, push, pop, ack, last_ack, start_acc, fifo_full, fifo_empty;

  assign fifo_full  = (fifo_cnt_q == FIFO_FULL);
  assign fifo_empty = (fifo_cnt_q == '0);
  assign pix_ready  = (state_q == LOAD) && (pix_cnt_q < PIX_TOTAL) && !fifo_full;
  assign pix_acc    = pix_valid && pix_ready;
  // The fourth pixel of a group completes a word, so it is written to the
  // FIFO on the same edge that accepts the pixel.
  assign push       = pix_acc && (byte_cnt_q == 2'd3);
  // The previous-cycle-ack gate keeps ready low for at least one whole cycle
  // between words. This matches the NCC's two-state WAIT/LOAD cadence.
  assign pop        = !ready_q && !fifo_empty && !ack_prev_q;
  assign ack        = (state_q == LOAD) && ready_q && done_with_desc_data;
  assign last_ack   = ack && (word_cnt_q == WORD_LAST);
  assign start_acc  = (state_q == IDLE) && start;

  assign busy            = (state_q != IDLE);
  assign desc_loaded     = (state_q == DONE);
  assign desc_data       = data_q;
  assign desc_data_ready = ready_q;
  assign word_count      = word_cnt_q;
  assign start_err       = err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)    state_d = LOAD;
      LOAD:    if (last_ack) state_d = DONE;
      DONE:                  state_d = IDLE;
      default:               state_d = IDLE;
    endcase
  end

  // FIFO storage is not reset. Occupancy is tracked by the counters below,
  // so stale entries are never observed.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {pack_q, pix_data};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pix_cnt_q  <= '0;
      byte_cnt_q <= '0;
      pack_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      data_q     <= '0;
      ready_q    <= 1'b0;
      ack_prev_q <= 1'b0;
      word_cnt_q <= '0;
      err_q      <= 1'b0;
    end else if (start_acc) begin
      pix_cnt_q  <= '0;
      byte_cnt_q <= '0;
      pack_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      ready_q    <= 1'b0;
      ack_prev_q <= 1'b0;
      word_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      if (start && (state_q != IDLE)) err_q <= 1'b1;
      // Shifting pixels in from the bottom leaves the first pixel of the
      // group in the top byte once four have arrived.
      if (pix_acc) begin
        pix_cnt_q  <= pix_cnt_q + 1'b1;
        byte_cnt_q <= byte_cnt_q + 2'd1;
        pack_q     <= {pack_q[2*PIX_W-1:0], pix_data};
      end
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) begin
        data_q   <= mem_q[rd_ptr_q];
        rd_ptr_q <= rd_ptr_q + 1'b1;
        ready_q  <= 1'b1;
      end
      if (ack) begin
        ready_q    <= 1'b0;
        word_cnt_q <= last_ack ? '0 : word_cnt_q + 1'b1;
      end
      ack_prev_q <= ack;
      case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + 1'b1;
        2'b01:   fifo_cnt_q <= fifo_cnt_q - 1'b1;
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

`ifdef DESC_FEEDER_CHECKSUM_EN
  logic [15:0] csum_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         csum_q <= '0;
    else if (start_acc) csum_q <= '0;
    else if (pix_acc)   csum_q <= csum_q + 16'(pix_data);
  end

  assign desc_checksum = csum_q;
`endif

endmodule

// File: tb/tb_desc_feeder.sv
// tb_desc_feeder
// ---------------------------------------------------------------------------
// Self-checking bench for desc_feeder. A table of load scenarios drives
// randomized pixel/acknowledge traffic. A queue-based reference model
// predicts every output on every cycle. Hand-written sequences cover the
// reset state and the first-word latency. Define DESC_FEEDER_CHECKSUM_EN
// to also check desc_checksum.
// ---------------------------------------------------------------------------
module tb_desc_feeder;

  localparam int NW = 64;
  localparam int FD = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        pix_valid;
  logic [7:0]  pix_data;
  logic        pix_ready;
  logic [31:0] desc_data;
  logic        desc_data_ready;
  logic        done_ack;
  logic        busy;
  logic        desc_loaded;
  logic [5:0]  word_count;
  logic        start_err;
`ifdef DESC_FEEDER_CHECKSUM_EN
  logic [15:0] desc_checksum;
`endif

  int tests = 0;
  int fails = 0;

  // Reference model state. The FIFO and the pixel packer are plain queues.
  bit          mLoad, mDone, mReady, mPrevAck, mErr;
  int          mAccepted, mAcks;
  logic [31:0] mData;
  logic [15:0] mSum;
  logic [7:0]  pixQ[$];
  logic [31:0] fifoQ[$];

  typedef struct {
    int pixMode;      // 0 = sequential index, 1 = random, 2 = all 0xFF
    int gapPct;       // percent chance of pix_valid low in a cycle
    int ackDelay;     // cycles of ready before ack; negative = random ack
    int holdFirst;    // extra ack hold on the first word
    bit strayAck;     // toggle ack randomly while ready is low
    int startAtWord;  // pulse start while busy at this word, -1 = never
    int resetAtWord;  // assert reset at this word, -1 = never
    int expLoaded;    // desc_loaded pulses expected
    bit expErrEnd;    // start_err expected at end
    int expAcks;      // handshakes expected
  } vec_t;

  vec_t vecs[7];

  desc_feeder #(.NUM_WORDS(NW), .FIFO_DEPTH(FD), .PIX_W(8)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .start               (start),
    .pix_valid           (pix_valid),
    .pix_data            (pix_data),
    .pix_ready           (pix_ready),
    .desc_data           (desc_data),
    .desc_data_ready     (desc_data_ready),
    .done_with_desc_data (done_ack),
    .busy                (busy),
    .desc_loaded         (desc_loaded),
    .word_count          (word_count),
    .start_err           (start_err)
`ifdef DESC_FEEDER_CHECKSUM_EN
    ,
    .desc_checksum       (desc_checksum)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mLoad = 0; mDone = 0; mReady = 0; mPrevAck = 0; mErr = 0;
    mAccepted = 0; mAcks = 0; mData = '0; mSum = '0;
    pixQ.delete();
    fifoQ.delete();
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic modelStep();
    bit acc, ack, pop, stAcc;
    acc   = mLoad && pix_valid && (mAccepted < 4 * NW) && (fifoQ.size() < FD);
    ack   = mLoad && mReady && done_ack;
    pop   = !mReady && (fifoQ.size() > 0) && !mPrevAck;
    stAcc = !(mLoad || mDone) && start;
    mDone = 0;
    if (stAcc) begin
      mLoad = 1; mAcks = 0; mErr = 0; mAccepted = 0; mSum = '0;
      pixQ.delete();
      fifoQ.delete();
    end else begin
      if (start) mErr = 1;
      if (mLoad) begin
        if (pop) begin
          mData  = fifoQ.pop_front();
          mReady = 1;
        end
        if (ack) begin
          mReady = 0;
          mAcks++;
          if (mAcks == NW) begin
            mAcks = 0; mLoad = 0; mDone = 1;
          end
        end
        if (acc) begin
          pixQ.push_back(pix_data);
          mAccepted++;
          mSum = mSum + 16'(pix_data);
          if (pixQ.size() == 4) begin
            fifoQ.push_back({pixQ[0], pixQ[1], pixQ[2], pixQ[3]});
            pixQ.delete();
          end
        end
      end
    end
    mPrevAck = ack;
  endtask

  task automatic checkAllOutputs();
    bit expPixReady;
    expPixReady = mLoad && (mAccepted < 4 * NW) && (fifoQ.size() < FD);
    checkOutput("pix_ready", 32'(pix_ready), 32'(expPixReady));
    checkOutput("desc_data_ready", 32'(desc_data_ready), 32'(mReady));
    if (mReady) checkOutput("desc_data", desc_data, mData);
    checkOutput("busy", 32'(busy), 32'(mLoad || mDone));
    checkOutput("desc_loaded", 32'(desc_loaded), 32'(mDone));
    checkOutput("word_count", 32'(word_count), 32'(mAcks % NW));
    checkOutput("start_err", 32'(start_err), 32'(mErr));
`ifdef DESC_FEEDER_CHECKSUM_EN
    if (mDone) checkOutput("desc_checksum", 32'(desc_checksum), 32'(mSum));
`endif
  endtask

  // One clock: predict, let the edge happen, then sample 1 ns later.
  task automatic cycle();
    modelStep();
    @(posedge clk);
    #1;
    checkAllOutputs();
  endtask

  // Asynchronous reset: outputs must clear without waiting for an edge.
  task automatic resetMidLoad();
    rst = 1'b0; start = 1'b0; pix_valid = 1'b0; done_ack = 1'b0;
    #1;
    checkOutput("rst_pix_ready", 32'(pix_ready), 32'h0);
    checkOutput("rst_desc_data_ready", 32'(desc_data_ready), 32'h0);
    checkOutput("rst_desc_data", desc_data, 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    checkOutput("rst_desc_loaded", 32'(desc_loaded), 32'h0);
    checkOutput("rst_word_count", 32'(word_count), 32'h0);
    checkOutput("rst_start_err", 32'(start_err), 32'h0);
`ifdef DESC_FEEDER_CHECKSUM_EN
    checkOutput("rst_desc_checksum", 32'(desc_checksum), 32'h0);
`endif
    modelReset();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // Run one full descriptor load from IDLE according to a table entry.
  task automatic applyStimulus(input vec_t v, input int idx);
    int   age, loadedSeen, acksSeen, presented, lowRun;
    bit   startPulsed, aborted, prevReady, timedOut;
    logic [7:0] b;
    age = 0; loadedSeen = 0; acksSeen = 0; presented = 0; lowRun = 0;
    startPulsed = 0; aborted = 0; prevReady = 0;
    start = 1'b1; pix_valid = 1'b0; done_ack = 1'b0;
    cycle();
    start = 1'b0;
    for (int cyc = 0; cyc < 6000 && (mLoad || mDone) && !aborted; cyc++) begin
      if (v.resetAtWord >= 0 && mLoad && mAcks == v.resetAtWord) begin
        resetMidLoad();
        aborted = 1;
      end else begin
        start = (v.startAtWord >= 0) && mLoad && (mAcks == v.startAtWord) && !startPulsed;
        if (start) startPulsed = 1;
        pix_valid = ($urandom_range(0, 99) >= 32'(v.gapPct));
        case (v.pixMode)
          0:       pix_data = 8'(mAccepted);
          1:       pix_data = 8'($urandom);
          default: pix_data = 8'hFF;
        endcase
        if (mReady) begin
          age++;
          if (v.ackDelay < 0) done_ack = 1'($urandom_range(0, 1));
          else done_ack = (age > v.ackDelay + ((mAcks == 0) ? v.holdFirst : 0));
        end else begin
          age = 0;
          done_ack = v.strayAck ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        if (desc_data_ready && done_ack) acksSeen++;
        if (v.pixMode == 0 && mReady && done_ack) begin
          b = 8'(mAcks * 4);
          checkOutput("seq_word", desc_data, {b, b + 8'd1, b + 8'd2, b + 8'd3});
        end
`ifdef DESC_FEEDER_CHECKSUM_EN
        if (v.pixMode == 2 && mDone) checkOutput("csum_all_ff", 32'(desc_checksum), 32'h0000FF00);
`endif
        cycle();
        if (desc_loaded) loadedSeen++;
        if (desc_data_ready && !prevReady) begin
          if (presented > 0) checkOutput("ready_low_gap", 32'(lowRun >= 1), 32'h1);
          presented++;
        end
        lowRun    = desc_data_ready ? 0 : lowRun + 1;
        prevReady = desc_data_ready;
      end
    end
    timedOut = (mLoad || mDone) && !aborted;
    checkOutput($sformatf("vec%0d_in_budget", idx), 32'(timedOut), 32'h0);
    if (timedOut) resetMidLoad();
    start = 1'b0; pix_valid = 1'b0; done_ack = 1'b0;
    repeat (3) begin
      cycle();
      if (desc_loaded) loadedSeen++;
    end
    checkOutput($sformatf("vec%0d_loaded_pulses", idx), 32'(loadedSeen), 32'(v.expLoaded));
    checkOutput($sformatf("vec%0d_start_err_end", idx), 32'(start_err), 32'(v.expErrEnd));
    checkOutput($sformatf("vec%0d_acks", idx), 32'(acksSeen), 32'(v.expAcks));
  endtask

  initial begin
    // pixMode gap ackDly hold stray startAt resetAt loaded err acks
    vecs[0] = '{0, 0,   1,  0, 1'b0, -1, -1, 1, 1'b0, 64};
    vecs[1] = '{0, 0,   1, 20, 1'b0, -1, -1, 1, 1'b0, 64};
    vecs[2] = '{1, 30, -1,  0, 1'b1, -1, -1, 1, 1'b0, 64};
    vecs[3] = '{1, 0,   1,  0, 1'b0, 10, -1, 1, 1'b1, 64};
    vecs[4] = '{0, 10,  2,  0, 1'b1, -1, 30, 0, 1'b0, 30};
    vecs[5] = '{0, 0,   1,  0, 1'b0, -1, -1, 1, 1'b0, 64};
    vecs[6] = '{2, 0,   0,  0, 1'b0, -1, -1, 1, 1'b0, 64};

    rst = 1'b1; start = 1'b0; pix_valid = 1'b0; pix_data = '0; done_ack = 1'b0;
    modelReset();
    @(posedge clk);
    #1;
    // Reset state straight out of power-up.
    resetMidLoad();

    // First word appears one edge after its fourth pixel is accepted.
    start = 1'b1;
    cycle();
    start = 1'b0;
    pix_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pix_data = 8'(160 + i);
      cycle();
    end
    pix_valid = 1'b0;
    checkOutput("latency_not_yet", 32'(desc_data_ready), 32'h0);
    cycle();
    checkOutput("latency_ready", 32'(desc_data_ready), 32'h1);
    checkOutput("latency_word", desc_data, 32'hA0A1A2A3);
    resetMidLoad();

    for (int i = 0; i < 7; i++) applyStimulus(vecs[i], i);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/desc_feeder.md
Name: desc_feeder

Overview:
- Transmit side of the descriptor-load interface into the 16x16 NCC PE grid.
- Accepts a 256-pixel descriptor as an 8-bit pixel stream and packs four pixels per 32-bit word, first pixel in [31:24].
- Buffers packed words in a small FIFO and presents them one at a time via desc_data_ready / done_with_desc_data, so the NCC row/column-group counters step through all 64 words.
- Signals completion when all 64 words have been acknowledged.

Parameters:
NUM_WORDS, 64, packed words per descriptor (16 rows x 4 column groups)
FIFO_DEPTH, 4, packed-word FIFO entries (power of 2, >=2)
PIX_W, 8, descriptor pixel width; word width is 4*PIX_W

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
start  input  1  begin a new descriptor load (sampled in IDLE only)
pix_valid  input  1  upstream pixel valid
pix_data  input  PIX_W  upstream pixel
pix_ready  output  1  pixel accepted when pix_valid && pix_ready
desc_data  output  4*PIX_W  packed word to NCC desc_data_in
desc_data_ready  output  1  desc_data valid, held until acknowledged
done_with_desc_data  input  1  NCC acknowledge of current word
busy  output  1  load in progress
desc_loaded  output  1  one-cycle pulse after final acknowledge
word_count  output  $clog2(NUM_WORDS)  words acknowledged so far
start_err  output  1  sticky: start seen while busy

Behaviour:
- Reset (rst low, asynchronous): all outputs 0; FIFO empty; byte/word counters 0; state IDLE. Reset mid-load abandons the descriptor without a desc_loaded pulse.
- States: IDLE, LOAD, DONE.
  - IDLE: start -> LOAD at next edge; clears word_count and start_err.
  - LOAD: active until the NUM_WORDS-th acknowledge -> DONE.
  - DONE: desc_loaded=1 for exactly one cycle -> IDLE.
- busy=1 in LOAD and DONE.
- start while busy: ignored; sets start_err (cleared only by the next accepted start).
- Pack side:
  - pix_ready = (state==LOAD) && fewer than 4*NUM_WORDS pixels accepted && FIFO not full.
  - A 2-bit byte counter places pixels at [31:24], [23:16], [15:8], [7:0].
  - The 4th accepted pixel writes the completed word into the FIFO at that edge.
  - After 256 pixels are accepted, pix_ready stays 0 until the next start.
- Present side:
  - When desc_data_ready=0, the FIFO is non-empty, and the previous cycle was not an acknowledge cycle: pop the head into the desc_data register and set desc_data_ready=1 at that edge.
  - Minimum latency: 4th pixel accepted at edge N -> desc_data_ready=1 after edge N+1.
  - desc_data and desc_data_ready stay stable until done_with_desc_data=1 is sampled with desc_data_ready=1.
  - At that edge: desc_data_ready -> 0 and word_count increments.
  - desc_data_ready is low for at least one full cycle between words, matching the NCC two-state WAIT/LOAD cadence.
  - done_with_desc_data while desc_data_ready=0 is ignored.
- Simultaneous FIFO push and pop in one cycle is legal; occupancy is unchanged.
- word_count wraps to 0 on the final acknowledge; desc_loaded follows in the DONE cycle.
- Width rule: all counters are unsigned, no saturation. Pixel-count counter width is $clog2(4*NUM_WORDS)+1.

Optional Feature:
- Macro: DESC_FEEDER_CHECKSUM_EN.
- When defined:
  - Adds output desc_checksum[15:0], the modular 16-bit sum of all accepted pixels.
  - Cleared on accepted start and on reset.
  - Valid and stable from the desc_loaded pulse until the next start.
- When undefined: port and adder are absent; behaviour is otherwise identical.

Test Plan:
- Reset then start, stream pixels 0..255 back-to-back, NCC acks 1 cycle after each ready.
  - Words are 0x00010203, 0x04050607, ..., 0xFCFDFEFF in order.
  - desc_loaded pulses once; word_count returns to 0; busy drops.
- Hold done_with_desc_data=0 for 20 cycles after the first word.
  - desc_data_ready and desc_data stay stable; the FIFO fills to FIFO_DEPTH.
  - pix_ready goes 0 once the FIFO is full and the next word is complete.
  - Releasing ack drains the FIFO with >=1 low cycle between ready pulses.
- Pulse done_with_desc_data while desc_data_ready=0 -> no word_count change, no FIFO pop.
- Pulse start at word 10 -> start_err=1, load continues unaffected.
  - The next start in IDLE clears start_err.
- Drive rst low mid-load at word 30, then release -> all outputs 0 and no desc_loaded pulse.
  - A fresh start loads 64 words correctly.
- With DESC_FEEDER_CHECKSUM_EN and all pixels 0xFF -> desc_checksum = 0xFF00 at desc_loaded.
